// File: rtl/dec_pkg.sv
// Shared definitions for the scanning N-to-M decoder: mode encodings, the
// reset-time table contents and the parameter sanity check.
package dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest table entry the init helper can describe.
  localparam int TBL_MAX_W = 64;

  // Reset value of table entry k: one-hot(k) while k fits in the output, else zero.
  function automatic logic [TBL_MAX_W-1:0] onehot_entry(input int k, input int out_w);
    logic [TBL_MAX_W-1:0] v;
    v = '0;
    if (k >= 0 && k < out_w && k < TBL_MAX_W) begin
      v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic bit params_ok(input int in_w, input int out_w,
                                   input int last_code, input int prescale);
    return (in_w >= 1) && (in_w <= 16) &&
           (out_w >= 1) && (out_w <= TBL_MAX_W) &&
           (last_code >= 0) && (last_code < (1 << in_w)) &&
           (prescale >= 1);
  endfunction

endpackage

// File: rtl/dec_prescaler.sv
// Scan-rate divider: counts 0..PRESCALE-1 and flags the final count as a tick.
// clear forces the count to zero; hold freezes it.
module dec_prescaler
  import dec_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_reg;

  // The tick is consumed by registers in the top level only.
  assign tick = !clear && !hold && (count_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (hold) begin
      count_reg <= count_reg;
    end else if (count_reg == CNT_LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dec_scan_nto_m.sv
// Registered N-to-M decoder with a writable code table, decoding either the
// input code directly or an internally scanned index at a prescaled rate.
module dec_scan_nto_m
  import dec_pkg::*;
#(
  parameter int IN_W      = 3,
  parameter int OUT_W     = 6,
  parameter int LAST_CODE = 5,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [IN_W-1:0]  a,
  input  logic             tbl_we,
  input  logic [IN_W-1:0]  tbl_addr,
  input  logic [OUT_W-1:0] tbl_data,
  output logic [OUT_W-1:0] y,
  output logic [IN_W-1:0]  scan_idx,
  output logic             step
);

  localparam int DEPTH = 2 ** IN_W;
  localparam logic [IN_W-1:0] LAST_IDX = IN_W'(LAST_CODE);

  if (!params_ok(IN_W, OUT_W, LAST_CODE, PRESCALE)) begin : g_bad_params
    $error("dec_scan_nto_m: illegal parameter combination");
  end

  // Table lives in flops so that reset can restore the one-hot contents.
  logic [DEPTH-1:0][OUT_W-1:0] tbl_flat;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_tbl
    localparam logic [TBL_MAX_W-1:0] INIT_FULL = onehot_entry(gi, OUT_W);
    localparam logic [OUT_W-1:0]     INIT_VAL  = INIT_FULL[OUT_W-1:0];
    logic [OUT_W-1:0] entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= INIT_VAL;
      end else if (tbl_we && (tbl_addr == IN_W'(gi))) begin
        entry_reg <= tbl_data;
      end
    end

    assign tbl_flat[gi] = entry_reg;
  end

  logic            mode_prev_reg;
  logic            entering;
  logic            tick;
  logic [IN_W-1:0] scan_next;

  assign entering  = (mode == MODE_SCAN) && (mode_prev_reg == MODE_DIRECT);
  assign scan_next = (scan_idx == LAST_IDX) ? '0 : scan_idx + IN_W'(1);

  dec_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((mode == MODE_DIRECT) || entering),
    .hold  (!en),
    .tick  (tick)
  );

  // Reads of tbl_flat here see the pre-write value, so a same-cycle write
  // becomes visible on y one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y             <= '0;
      scan_idx      <= '0;
      step          <= 1'b0;
      mode_prev_reg <= MODE_DIRECT;
    end else begin
      mode_prev_reg <= mode;
      if (mode == MODE_DIRECT) begin
        scan_idx <= '0;
        step     <= 1'b0;
        y        <= en ? tbl_flat[a] : '0;
      end else if (entering) begin
        scan_idx <= '0;
        step     <= 1'b0;
        y        <= en ? tbl_flat[0] : '0;
      end else if (!en) begin
        step <= 1'b0;
        y    <= '0;
      end else if (tick) begin
        scan_idx <= scan_next;
        step     <= 1'b1;
        y        <= tbl_flat[scan_next];
      end else begin
        step <= 1'b0;
        y    <= tbl_flat[scan_idx];
      end
    end
  end

endmodule

// File: tb/tb_dec_scan_nto_m.sv
// Directed bench for dec_scan_nto_m: default build plus a PRESCALE=1 build
// driven by the same inputs.
module tb_dec_scan_nto_m;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] a;
  logic       tbl_we;
  logic [2:0] tbl_addr;
  logic [5:0] tbl_data;
  logic [5:0] y;
  logic [2:0] scan_idx;
  logic       step;
  logic [5:0] y2;
  logic [2:0] scan_idx2;
  logic       step2;

  int total;
  int bad;

  dec_scan_nto_m #(.IN_W(3), .OUT_W(6), .LAST_CODE(5), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .y(y), .scan_idx(scan_idx), .step(step)
  );

  dec_scan_nto_m #(.IN_W(3), .OUT_W(6), .LAST_CODE(5), .PRESCALE(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .y(y2), .scan_idx(scan_idx2), .step(step2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; reset is asserted and released between edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_y", y, 0);
    chk_eq("rst_scan", scan_idx, 0);
    chk_eq("rst_step", step, 0);
    #2 rst_n = 1'b1;
  endtask

  int exp_y [8] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h00};

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    en = 1'b0;
    mode = 1'b0;
    a = '0;
    tbl_we = 1'b0;
    tbl_addr = '0;
    tbl_data = '0;

    #12;
    chk_eq("init_y", y, 0);
    chk_eq("init_scan", scan_idx, 0);
    chk_eq("init_step", step, 0);
    #1 rst_n = 1'b1;

    // DIRECT decode of every code
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      cyc();
      chk_eq($sformatf("direct_a%0d", i), y, exp_y[i]);
    end

    // enable gating
    a = 3'd2;
    en = 1'b0;
    cyc();
    chk_eq("en_off_y", y, 0);
    en = 1'b1;
    cyc();
    chk_eq("en_on_y", y, 6'h04);

    // table write with same-cycle read of that entry
    a = 3'd3;
    tbl_we = 1'b1;
    tbl_addr = 3'd3;
    tbl_data = 6'b001010;
    cyc();
    chk_eq("wr_old_y", y, 6'h08);
    tbl_we = 1'b0;
    cyc();
    chk_eq("wr_new_y", y, 6'h0A);
    do_reset();
    cyc();
    chk_eq("wr_reset_y", y, 6'h08);

    // SCAN from reset
    do_reset();
    mode = 1'b1;
    en = 1'b1;
    cyc();
    chk_eq("scan_entry_idx", scan_idx, 0);
    chk_eq("scan_entry_y", y, 6'h01);
    chk_eq("scan_entry_step", step, 0);
    chk_eq("fast_entry_idx", scan_idx2, 0);
    for (int c = 1; c <= 34; c++) begin
      cyc();
      chk_eq($sformatf("scan_idx_c%0d", c), scan_idx, (c / 4) % 6);
      chk_eq($sformatf("scan_step_c%0d", c), step, (c % 4 == 0) ? 1 : 0);
      chk_eq($sformatf("scan_y_c%0d", c), y, 1 << ((c / 4) % 6));
      chk_eq($sformatf("fast_idx_c%0d", c), scan_idx2, c % 6);
      chk_eq($sformatf("fast_step_c%0d", c), step2, 1);
    end

    // en dropped at scan_idx=2 with prescale count at 2
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk_eq($sformatf("hold_y_%0d", c), y, 0);
      chk_eq($sformatf("hold_idx_%0d", c), scan_idx, 2);
      chk_eq($sformatf("hold_step_%0d", c), step, 0);
    end
    en = 1'b1;
    cyc();
    chk_eq("resume_idx", scan_idx, 2);
    chk_eq("resume_y", y, 6'h04);
    chk_eq("resume_step", step, 0);
    cyc();
    chk_eq("resume_adv_idx", scan_idx, 3);
    chk_eq("resume_adv_y", y, 6'h08);
    chk_eq("resume_adv_step", step, 1);
    for (int c = 0; c < 4; c++) cyc();
    chk_eq("pre_rst_idx", scan_idx, 4);

    // reset mid-scan, then restart at code 0
    do_reset();
    cyc();
    chk_eq("restart_idx", scan_idx, 0);
    chk_eq("restart_y", y, 6'h01);
    chk_eq("fast_restart_idx", scan_idx2, 0);
    cyc();
    chk_eq("fast_restart_adv", scan_idx2, 1);
    chk_eq("fast_restart_step", step2, 1);
    for (int c = 0; c < 3; c++) cyc();
    chk_eq("restart_adv_idx", scan_idx, 1);
    chk_eq("restart_adv_step", step, 1);
    chk_eq("restart_adv_y", y, 6'h02);

    // leaving SCAN returns to DIRECT decode on the next edge
    mode = 1'b0;
    a = 3'd5;
    cyc();
    chk_eq("leave_y", y, 6'h20);
    chk_eq("leave_idx", scan_idx, 0);
    chk_eq("leave_step", step, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
